// File: rtl/apb_gpio_irq.sv
// APB4 GPIO with per-pin synchroniser, shared-prescaler debounce, level/edge
// triggers, sticky W1C status and one registered combined interrupt.

module apb_gpio_irq_pin #(
    parameter int SYNC_STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic pin_i,
    input  logic bypass_i,
    input  logic tick_i,
    input  logic hist_vld_i,
    input  logic trig_type_i,
    input  logic trig_pol_i,
    output logic in_o,
    output logic set_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sample_q, sample_d;
    logic                   in_q, in_d;
    logic                   in_prev_q, in_prev_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pin_i};
        sample_d  = tick_i ? synced : sample_q;
        in_prev_d = in_q;
        in_d      = in_q;
        if (bypass_i)
            in_d = synced;
        // A tick accepts the pin only if it matches the previous tick's sample.
        else if (tick_i && hist_vld_i && (synced == sample_q))
            in_d = synced;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q    <= '0;
            sample_q  <= 1'b0;
            in_q      <= 1'b0;
            in_prev_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            sample_q  <= sample_d;
            in_q      <= in_d;
            in_prev_q <= in_prev_d;
        end
    end

    assign in_o  = in_q;
    assign set_o = trig_type_i ? ((in_prev_q != in_q) && (in_q == trig_pol_i))
                               : (in_q == trig_pol_i);
endmodule

module apb_gpio_irq #(
    parameter int PDATA_SIZE    = 8,
    parameter int PADDR_SIZE    = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [PDATA_SIZE-1:0]   gpio_i,
    output logic [PDATA_SIZE-1:0]   gpio_o,
    output logic [PDATA_SIZE-1:0]   gpio_oe,
    output logic                    irq_o
);
    localparam int NBYTES = PDATA_SIZE / 8;
    localparam int ALSB   = (NBYTES > 1) ? $clog2(NBYTES) : 0;

    localparam logic [2:0] R_DIR  = 3'd0;
    localparam logic [2:0] R_OUT  = 3'd1;
    localparam logic [2:0] R_IN   = 3'd2;
    localparam logic [2:0] R_TYPE = 3'd3;
    localparam logic [2:0] R_POL  = 3'd4;
    localparam logic [2:0] R_STAT = 3'd5;
    localparam logic [2:0] R_ENA  = 3'd6;
    localparam logic [2:0] R_DBNC = 3'd7;

    logic [PDATA_SIZE-1:0]    dir_q, dir_d, out_q, out_d, type_q, type_d;
    logic [PDATA_SIZE-1:0]    pol_q, pol_d, stat_q, stat_d, ena_q, ena_d;
    logic [DEBOUNCE_BITS-1:0] dbnc_q, dbnc_d, cnt_q, cnt_d;
    logic                     hist_q, hist_d, irq_q, irq_d;

    logic [2:0]               idx;
    logic                     wr_en, tick, bypass;
    logic [PDATA_SIZE-1:0]    bmask, in_vec, trig_set, dbnc_wide;
    logic                     unused_paddr;

    assign idx          = PADDR[ALSB+2:ALSB];
    assign unused_paddr = ^PADDR;
    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign dbnc_wide    = PDATA_SIZE'(dbnc_q);

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NBYTES; b++)
            bmask[b*8 +: 8] = {8{PSTRB[b]}};
    end

    // Prescaler: counts 0..N, one tick at N; a DEBOUNCE write restarts it
    // and forgets the previous sample so the next tick only records.
    always_comb begin
        bypass = (dbnc_q == '0);
        tick   = !bypass && (cnt_q >= dbnc_q) && !(wr_en && idx == R_DBNC);
        cnt_d  = (bypass || tick) ? '0 : cnt_q + 1'b1;
        hist_d = bypass ? 1'b0 : (hist_q | tick);
        if (wr_en && idx == R_DBNC) begin
            cnt_d  = '0;
            hist_d = 1'b0;
        end
    end

    for (genvar i = 0; i < PDATA_SIZE; i++) begin : g_pin
        apb_gpio_irq_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .PCLK        (PCLK),
            .PRESETn     (PRESETn),
            .pin_i       (gpio_i[i]),
            .bypass_i    (bypass),
            .tick_i      (tick),
            .hist_vld_i  (hist_q),
            .trig_type_i (type_q[i]),
            .trig_pol_i  (pol_q[i]),
            .in_o        (in_vec[i]),
            .set_o       (trig_set[i])
        );
    end

    always_comb begin
        dir_d  = dir_q;
        out_d  = out_q;
        type_d = type_q;
        pol_d  = pol_q;
        ena_d  = ena_q;
        dbnc_d = dbnc_q;
        stat_d = stat_q;
        if (wr_en) begin
            case (idx)
                R_DIR:   dir_d  = (dir_q  & ~bmask) | (PWDATA & bmask);
                R_OUT:   out_d  = (out_q  & ~bmask) | (PWDATA & bmask);
                R_TYPE:  type_d = (type_q & ~bmask) | (PWDATA & bmask);
                R_POL:   pol_d  = (pol_q  & ~bmask) | (PWDATA & bmask);
                R_ENA:   ena_d  = (ena_q  & ~bmask) | (PWDATA & bmask);
                R_DBNC:  dbnc_d = DEBOUNCE_BITS'((dbnc_wide & ~bmask) | (PWDATA & bmask));
                R_STAT:  stat_d = stat_q & ~(PWDATA & bmask);
                default: ;
            endcase
        end
        // New trigger events override a same-cycle clear.
        stat_d = stat_d | trig_set;
        irq_d  = |(stat_q & ena_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dir_q  <= '0;
            out_q  <= '0;
            type_q <= '0;
            pol_q  <= '0;
            stat_q <= '0;
            ena_q  <= '0;
            dbnc_q <= '0;
            cnt_q  <= '0;
            hist_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            out_q  <= out_d;
            type_q <= type_d;
            pol_q  <= pol_d;
            stat_q <= stat_d;
            ena_q  <= ena_d;
            dbnc_q <= dbnc_d;
            cnt_q  <= cnt_d;
            hist_q <= hist_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (idx)
                R_DIR:   PRDATA = dir_q;
                R_OUT:   PRDATA = out_q;
                R_IN:    PRDATA = in_vec;
                R_TYPE:  PRDATA = type_q;
                R_POL:   PRDATA = pol_q;
                R_STAT:  PRDATA = stat_q;
                R_ENA:   PRDATA = ena_q;
                default: PRDATA = dbnc_wide;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = wr_en && (idx == R_IN);
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq_o   = irq_q;
endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq: register table plus hand-timed trigger,
// debounce and reset sequences.

module tb_apb_gpio_irq;
    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [0:0] PSTRB;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic [7:0] gpio_i, gpio_o, gpio_oe;
    logic       irq_o;

    int total = 0;
    int bad   = 0;

    apb_gpio_irq dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] wdata;
        logic       strb;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic apb_write(input logic [2:0] idx, input logic [7:0] d,
                             input logic s, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = {2'b00, idx}; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] d);
        logic e;
        apb_write(idx, d, 1'b1, e);
    endtask

    task automatic apb_read(input logic [2:0] idx, output logic [7:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {2'b00, idx};
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;

        vecs[0] = '{3'd0, 8'hF0, 1'b1, 1'b0, 8'hF0};
        vecs[1] = '{3'd1, 8'hA5, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{3'd1, 8'h5A, 1'b0, 1'b0, 8'hA5};
        vecs[3] = '{3'd0, 8'h0F, 1'b0, 1'b0, 8'hF0};
        vecs[4] = '{3'd2, 8'hFF, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{3'd6, 8'h3C, 1'b1, 1'b0, 8'h3C};
        vecs[6] = '{3'd6, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{3'd7, 8'h07, 1'b1, 1'b0, 8'h07};
        vecs[8] = '{3'd7, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[9] = '{3'd4, 8'h00, 1'b1, 1'b0, 8'h00};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PSTRB = '0; PWDATA = '0; gpio_i = 8'h00;

        // Reset state, with reads taken while reset is still held.
        cyc(2);
        check("rst_gpio_o", gpio_o, 8'h00);
        check("rst_gpio_oe", gpio_oe, 8'h00);
        check("rst_irq", irq_o, 1'b0);
        check("rst_pready", PREADY, 1'b1);
        check("rst_pslverr", PSLVERR, 1'b0);
        PSEL = 1'b1; PWRITE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PADDR = 5'(i);
            #1 check($sformatf("rst_rd%0d", i), PRDATA, 8'h00);
        end
        PSEL = 1'b0;
        @(negedge PCLK) PRESETn = 1'b1;
        cyc(3);

        // Default level-low trigger with IN=0 sets every status bit.
        apb_read(3'd5, rd);
        check("default_lvl_low_status", rd, 8'hFF);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF);
        apb_read(3'd5, rd);
        check("status_cleared", rd, 8'h00);

        for (int i = 0; i < 10; i++) begin
            apb_write(vecs[i].idx, vecs[i].wdata, vecs[i].strb, err);
            check($sformatf("vec%0d_pslverr", i), err, vecs[i].exp_err);
            apb_read(vecs[i].idx, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end
        check("tbl_gpio_oe", gpio_oe, 8'hF0);
        check("tbl_gpio_o", gpio_o, 8'hA5);
        check("tbl_pready", PREADY, 1'b1);

        // gpio_o changes exactly at the access-phase edge.
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 5'd1; PWDATA = 8'h3C; PSTRB = 1'b1;
        cyc(1);
        PENABLE = 1'b1;
        #1 check("out_before_commit", gpio_o, 8'hA5);
        cyc(1);
        check("out_after_commit", gpio_o, 8'h3C);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;

        // Edge latency on bit 0: status after edge 3, irq after edge 4.
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'h01);
        wr(3'd6, 8'h01);
        wr(3'd5, 8'hFF);
        cyc(1);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 5'd5;
        gpio_i = 8'h01;
        cyc(3);
        check("lat_e2_status", PRDATA, 8'h00);
        check("lat_e2_irq", irq_o, 1'b0);
        cyc(1);
        check("lat_e3_status", PRDATA, 8'h01);
        check("lat_e3_irq", irq_o, 1'b0);
        cyc(1);
        check("lat_e4_irq", irq_o, 1'b1);
        PSEL = 1'b0;

        // Edge mode: clear stays cleared while pin is steady high.
        wr(3'd5, 8'h01);
        cyc(1);
        check("edge_w1c_irq", irq_o, 1'b0);
        apb_read(3'd5, rd);
        check("edge_w1c_status", rd, 8'h00);
        // Level-high on bit 0 with pin high: status comes straight back.
        wr(3'd3, 8'hFE);
        cyc(1);
        wr(3'd5, 8'h01);
        apb_read(3'd5, rd);
        check("lvl_reset_status", rd, 8'h01);

        // Level-low on bit 3, W1C committed on the edge where the set fires.
        gpio_i = 8'h08;
        cyc(5);
        wr(3'd3, 8'hF7);
        wr(3'd4, 8'hF7);
        wr(3'd6, 8'h08);
        wr(3'd5, 8'hFF);
        apb_read(3'd5, rd);
        check("setwin_pre_status", rd, 8'h00);
        check("setwin_pre_irq", irq_o, 1'b0);
        gpio_i = 8'h00;
        cyc(2);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 5'd5; PWDATA = 8'h08; PSTRB = 1'b1;
        cyc(1);
        PENABLE = 1'b1;
        cyc(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("setwin_e3_irq", irq_o, 1'b0);
        cyc(1);
        check("setwin_e4_irq", irq_o, 1'b1);
        apb_read(3'd5, rd);
        check("setwin_status", rd, 8'h08);

        // Debounce N=4: tick every 5 cycles.
        wr(3'd7, 8'h04);
        cyc(12);
        gpio_i = 8'h04;
        cyc(3);
        gpio_i = 8'h00;
        cyc(20);
        apb_read(3'd2, rd);
        check("glitch_in", rd, 8'h00);
        apb_read(3'd5, rd);
        check("glitch_status", rd, 8'h08);

        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 5'd2;
        gpio_i = 8'h04;
        cyc(15);
        check("pulse_in_high", PRDATA, 8'h04);
        PSEL = 1'b0;
        gpio_i = 8'h00;
        apb_read(3'd5, rd);
        check("pulse_rise_status", rd, 8'h0C);
        wr(3'd5, 8'h04);
        cyc(30);
        apb_read(3'd2, rd);
        check("pulse_in_low", rd, 8'h00);
        apb_read(3'd5, rd);
        check("pulse_fall_status", rd, 8'h08);

        // Reset in the access phase of OUT=0xFF.
        check("pre_rst_irq", irq_o, 1'b1);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 5'd1; PWDATA = 8'hFF; PSTRB = 1'b1;
        cyc(1);
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        cyc(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge PCLK) PRESETn = 1'b1;
        cyc(1);
        check("mid_rst_gpio_o", gpio_o, 8'h00);
        check("mid_rst_gpio_oe", gpio_oe, 8'h00);
        check("mid_rst_irq", irq_o, 1'b0);
        apb_read(3'd1, rd);
        check("mid_rst_out", rd, 8'h00);
        cyc(2);
        check("mid_rst_irq_later", irq_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
